// File: rtl/cdb_arbiter_if.sv
// Common data bus bundle: per-source result handshake in, registered broadcast out.
// The master side is the arbiter; the slave side is whatever feeds and observes it.
interface cdb_arbiter_if #(
  parameter int N_SRC  = 4,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
);
  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]        src_valid;
  logic [N_SRC*TAG_W-1:0]  src_tag;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        src_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic [SRC_W-1:0]        cdb_src;

  modport master (
    input  src_valid, src_tag, src_data,
    output src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    output src_valid, src_tag, src_data,
    input  src_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB producer: one small result FIFO per functional unit, round-robin pick of a
// non-empty FIFO each cycle, registered {tag, data, src} broadcast.
module cdb_arbiter #(
  parameter int N_SRC  = 4,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  cdb_arbiter_if.master   bus
);
  localparam int SRC_W = $clog2(N_SRC);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0]  tag_mem_q  [N_SRC][DEPTH];
  logic [DATA_W-1:0] data_mem_q [N_SRC][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q   [N_SRC];
  logic [PTR_W-1:0]  rd_ptr_q   [N_SRC];
  logic [CNT_W-1:0]  cnt_q      [N_SRC];
  logic [CNT_W-1:0]  cnt_d      [N_SRC];
  logic [SRC_W-1:0]  rr_q;

  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [SRC_W-1:0]  cdb_src_q;

  logic [N_SRC-1:0]  full;
  logic [N_SRC-1:0]  push;
  logic [N_SRC-1:0]  pop;
  logic [SRC_W-1:0]  grant;
  logic              grant_vld;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      full[i] = (cnt_q[i] == CNT_W'(DEPTH));
    end
  end

  // No pass-through: a full FIFO refuses even while its head is being popped.
  assign bus.src_ready = ~full & {N_SRC{~(rst_i | flush_i)}};
  assign push          = bus.src_valid & bus.src_ready;

  // Scan from the far end so the entry closest to rr_q is the one left standing.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (cnt_q[(int'(rr_q) + k) % N_SRC] != '0) begin
        grant     = SRC_W'((int'(rr_q) + k) % N_SRC);
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      pop[i] = grant_vld && (grant == SRC_W'(i));
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < N_SRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      // Flush leaves the last broadcast payload in place; only reset clears it.
      if (rst_i) begin
        cdb_tag_q  <= '0;
        cdb_data_q <= '0;
        cdb_src_q  <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
        cnt_q[i] <= cnt_d[i];
      end
      cdb_valid_q <= grant_vld;
      if (grant_vld) begin
        cdb_tag_q  <= tag_mem_q[grant][rd_ptr_q[grant]];
        cdb_data_q <= data_mem_q[grant][rd_ptr_q[grant]];
        cdb_src_q  <= grant;
        rr_q       <= (int'(grant) == N_SRC - 1) ? '0 : grant + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (push[i]) begin
        tag_mem_q[i][wr_ptr_q[i]]  <= bus.src_tag[i*TAG_W +: TAG_W];
        data_mem_q[i][wr_ptr_q[i]] <= bus.src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Producer end of the common data bus (CDB): collects completed results from N functional units and broadcasts one {tag, data} per cycle to all CDB consumers.
- Consumers are the register status table, reservation stations and ROB.
- Each source has a small result FIFO with valid/ready backpressure; a round-robin arbiter picks one non-empty FIFO per cycle and drives a registered CDB.

Parameters:
N_SRC, 4, number of result sources (int ALU, mult, div, mem); must be 2..8
DEPTH, 2, entries per source FIFO; power of two, >=2
TAG_W, 6, ROB/RST tag width
DATA_W, 32, result data width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  sync discard of all buffered and in-flight results (mispredict recovery)
src_valid  in  N_SRC  per-source result valid
src_tag  in  N_SRC*TAG_W  per-source tag, source i at [i*TAG_W +: TAG_W]
src_data  in  N_SRC*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W]
src_ready  out  N_SRC  per-source FIFO can accept
cdb_valid  out  1  registered broadcast valid
cdb_tag  out  TAG_W  registered broadcast tag
cdb_data  out  DATA_W  registered broadcast data
cdb_src  out  $clog2(N_SRC)  index of the source that won this broadcast

Behaviour:
- Reset (rst=1 at edge):
  - All FIFOs empty; rr_ptr=0.
  - cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
  - src_ready is combinationally 0 while rst=1.
- src_ready[i] = !full[i] && !rst && !flush. There is no pass-through: a full FIFO rejects a push even when it is popped in the same cycle.
- Push: at an edge with src_valid[i] && src_ready[i], {tag, data} is written at wr_ptr[i]. The handshake is ignored when src_ready[i]=0; the source must hold its result.
- Arbitration (combinational, on FIFO state at the start of the cycle):
  - Grant goes to the first non-empty FIFO scanning rr_ptr, rr_ptr+1, ... mod N_SRC.
  - A push in the same cycle is not visible to arbitration.
- Pop/broadcast: at the edge after a grant g:
  - Head of FIFO g is popped.
  - cdb_valid=1, cdb_tag/cdb_data=head, cdb_src=g.
  - rr_ptr=(g+1) mod N_SRC.
- No grant: cdb_valid=0 at the next edge. cdb_tag/data/src hold their previous values; consumers qualify them with cdb_valid.
- Latency: a result accepted at edge k is on the CDB after edge k+1 at the earliest (1 cycle of FIFO residency). Minimum source-to-CDB latency is 2 edges.
- Throughput: exactly one broadcast per cycle when any FIFO is non-empty.
- Fairness: no source waits more than N_SRC-1 broadcasts once its FIFO head is valid.
- FIFO pointers:
  - Each FIFO has rd/wr pointers of $clog2(DEPTH) bits plus a count of $clog2(DEPTH)+1 bits.
  - Pointers wrap mod DEPTH.
  - A simultaneous push and pop on the same FIFO leaves count unchanged, with both pointers advancing.
- Flush (flush=1 at edge, rst=0):
  - All FIFOs emptied, rr_ptr=0, cdb_valid=0.
  - No push accepted that cycle; no broadcast occurs from the flush cycle.
  - rst takes priority over flush.
- Reset or flush mid-operation discards buffered entries silently; they are never broadcast.
- Tag uniqueness is the issuer's responsibility. The arbiter does not check for duplicate tags.

Test Plan:
- Reset: rst=1 for 2 cycles with src_valid=4'hF -> src_ready=0, cdb_valid=0. After release, src_ready=4'hF, and no broadcast until the first push plus 2 edges.
- Single result: src 2 pushes tag=6'h15, data=32'hDEADBEEF at edge k -> at edge k+2: cdb_valid=1, cdb_tag=6'h15, cdb_data=32'hDEADBEEF, cdb_src=2. At edge k+3: cdb_valid=0.
- Round-robin: all 4 sources push one result each (tags 1,2,3,4) at the same edge -> CDB shows tags 1,2,3,4 on 4 consecutive cycles, cdb_src=0,1,2,3. Then src 0 and 3 push again -> order is src 0 then 3 (rr_ptr wrapped to 0).
- Full/backpressure: src 1 holds valid with tags 10,11,12 while src 0 continuously has results -> src_ready[1] drops after 2 accepts. Tag 12 is accepted only after tag 10 broadcasts; broadcasts alternate src 0 / src 1.
- Simultaneous push+pop: src 3 FIFO at count 1 is granted and pushed in the same cycle -> count stays 1; the new tag is broadcast on a later turn with no loss or duplication.
- Flush: 3 FIFOs non-empty with tags 7,8,9; assert flush for 1 cycle -> cdb_valid=0 from the flush edge. Tags 7,8,9 never appear, and a fresh push after flush is broadcast 2 edges later with cdb_src matching its source.
